multi_sprite: RTL and testbench
===============================

# multi_sprite

Parametrised multi-sprite compositor that overlays NUM_SPRITES independently placed, scaled bitmaps onto the video timing stream. Drop-in successor to the single-sprite overlay: it has the same 7-cycle pixel latency and the same bitmap port style. It adds the following:
- per-sprite attribute registers, double-buffered and latched at frame start;
- fixed-index priority;
- a colour-key transparency;
- optional sticky collision flags.

It sits between the video timing generator (ext_count_h/v) and the colour mixer.

## Interface
Parameters:
- NUM_SPRITES, 4: sprite count, 1..8.
- SPRITE_WIDTH_BITS, 6: log2 sprite width in pixels.
- SPRITE_HEIGHT_BITS, 7: log2 sprite height in lines.
- BPP, 8: bits per pixel.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- bitmap_length  out  32  constant NUM_SPRITES << (SPRITE_WIDTH_BITS+SPRITE_HEIGHT_BITS).
- bitmap_address  in  32  bitmap write address. Upper bits select the sprite bank; lower ADDR_BITS give y*width+x.
- bitmap_din  in  BPP  bitmap write data.
- bitmap_dout  out  BPP  constant 0; the bitmap is write-only.
- bitmap_we  in  1  bitmap write strobe.
- bitmap_oe  in  1  unused.
- reg_address  in  8  attribute register index.
- reg_din  in  32  attribute write data.
- reg_we  in  1  attribute write strobe.
- reg_dout  out  32  registered read data, valid 1 cycle after reg_address.
- ext_count_h, ext_count_v  in  32 each  signed current pixel position.
- ext_color  out  BPP  composited colour, 7 cycles after ext_count.

## Operation
Register map (index i = sprite, 0..NUM_SPRITES-1):
- 4i+0: x, signed 16 bits.
- 4i+1: y, signed 16 bits.
- 4i+2: scale, 4 bits.
- 4i+3: enable, bit 0.
- 4N+0: collision flags, one bit per sprite; write-1-to-clear.
- 4N+1: colour key, BPP bits.
- Out-of-range indices: writes are ignored and reads return 0.

Attribute buffering and colour key:
- Register writes land in shadow copies.
- Shadow copies are copied to active copies on the cycle where ext_count_h==0 and ext_count_v==0 (frame start).
- The colour key is not shadowed and takes effect immediately.

Per-sprite pixel pipeline (all sprites in parallel):
- Stage 1: dx0 = ext_count_h[15:0] − x, and dy0 likewise. Both are signed, 32 bits wide.
- Stage 2: dx1 = (dx0 << scale) >>> 8, and dy1 likewise. The shift is arithmetic, so scale 8 gives 1:1, 9 gives 2× shrink and 7 gives 2× zoom.
- Stage 2: inside = enable and 0 ≤ dx1 < width and 0 ≤ dy1 < height.
- Stage 3: RAM read address = {dy1[H-1:0], dx1[W-1:0]}.
- Stage 4: the per-sprite bank RAM returns data; this is a read-first RAM.
- Stage 5: opaque_i = inside_i (delayed to stage 5) and data ≠ colour key.

Compositing:
- Stage 6: select the lowest-index opaque sprite. If no sprite is opaque, the colour is 0.
- Stage 7: the selected colour is registered onto ext_color.

Bitmap writes:
- A write goes to bank bitmap_address >> ADDR_BITS.
- Writes to banks ≥ NUM_SPRITES are ignored.

## Timing
- Pixel latency is exactly 7 cycles from ext_count_h/v to ext_color. It is independent of NUM_SPRITES.
- reg_dout is valid 1 cycle after reg_address; writes have 0-cycle visibility in the shadow copy.
- A write in the same cycle as the frame-start latch is not latched; it becomes active at the next frame start.
- Collision set and write-1-to-clear in the same cycle: the set wins.
- A bitmap write and a pixel read of the same address in the same cycle: the read returns the old data.
- Reset values: ext_color 0, reg_dout 0, all shadow and active attributes 0 (every sprite disabled), colour key 0, collision flags 0, and all pipeline registers 0.
- A reset asserted mid-frame forces ext_color to 0 immediately. ext_color stays 0 until sprites are re-enabled and a frame start passes.
- Bitmap RAM contents are not reset.

## Configuration
- MULTI_SPRITE_COLLISION_EN defined:
  - At stage 6, if two or more sprites are opaque, set the collision bit of every opaque sprite.
  - Collision bits are sticky until cleared by software.
- MULTI_SPRITE_COLLISION_EN undefined:
  - The collision logic is not built.
  - Register 4N+0 reads 0 and writes to it are ignored.

## Test plan
- Reset, then drive a full frame → ext_color is 0 throughout and reg_dout is 0.
- Sprite 0 at x=10, y=20, scale=8, enable=1; bitmap word 0 = 0x55; frame start → ext_color = 0x55 exactly 7 cycles after (h=10, v=20), and 0 at h=9 and h=74.
- Sprites 0 and 1 overlap, pixel values 0x11 and 0x22 → 0x11 shown. Set sprite 0's pixel equal to the colour key → 0x22 shown.
- Write x mid-frame → the old position is used until the next (0,0), then the new position.
- Scale=7 → each bitmap pixel is repeated for 2 h-counts. Scale=9 → every second bitmap pixel is shown.
- With MULTI_SPRITE_COLLISION_EN and an opaque overlap of sprites 1 and 2 → flags read 0b0110. Write 0b0010 → reads 0b0100. A clear issued in the same cycle as a new hit leaves the bit set.

Source files
------------

// File: rtl/multi_sprite.sv
// Multi-sprite compositor: NUM_SPRITES scaled bitmaps overlaid on the timing stream with 7-cycle latency.
// Define MULTI_SPRITE_COLLISION_EN to build the sticky per-sprite collision flags.
module multi_sprite #(
  parameter int unsigned NUM_SPRITES        = 4,
  parameter int unsigned SPRITE_WIDTH_BITS  = 6,
  parameter int unsigned SPRITE_HEIGHT_BITS = 7,
  parameter int unsigned BPP                = 8
) (
  input  logic           clk,
  input  logic           reset,
  output logic [31:0]    bitmap_length,
  input  logic [31:0]    bitmap_address,
  input  logic [BPP-1:0] bitmap_din,
  output logic [BPP-1:0] bitmap_dout,
  input  logic           bitmap_we,
  input  logic           bitmap_oe,
  input  logic [7:0]     reg_address,
  input  logic [31:0]    reg_din,
  input  logic           reg_we,
  output logic [31:0]    reg_dout,
  input  logic [31:0]    ext_count_h,
  input  logic [31:0]    ext_count_v,
  output logic [BPP-1:0] ext_color
);

  localparam int unsigned NS        = NUM_SPRITES;
  localparam int unsigned WB        = SPRITE_WIDTH_BITS;
  localparam int unsigned HB        = SPRITE_HEIGHT_BITS;
  localparam int unsigned ADDR_BITS = WB + HB;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam int unsigned SPR_W     = 1 << WB;
  localparam int unsigned SPR_H     = 1 << HB;
  localparam int unsigned REG_COLL  = 4 * NS;
  localparam int unsigned REG_KEY   = 4 * NS + 1;

  logic [NS-1:0][15:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d, x_ac_q, y_ac_q;
  logic [NS-1:0][3:0]  sc_sh_q, sc_sh_d, sc_ac_q;
  logic [NS-1:0]       en_sh_q, en_sh_d, en_ac_q;
  logic [BPP-1:0]      key_q, key_d;
  logic [31:0]         rd_q, rd_d;
  logic                frame_start_c;

  logic [NS-1:0][31:0]      dx0_q, dx0_d, dy0_q, dy0_d, dx1_c, dy1_c;
  logic [NS-1:0][3:0]       sc1_q;
  logic [NS-1:0]            en1_q;
  logic [NS-1:0][WB-1:0]    px2_q, px2_d;
  logic [NS-1:0][HB-1:0]    py2_q, py2_d;
  logic [NS-1:0]            in2_q, in2_d, in3_q, in4_q;
  logic [NS-1:0][ADDR_BITS-1:0] addr3_q;
  logic [NS-1:0][BPP-1:0]   rdata4_c, pix5_q;
  logic [NS-1:0]            opq5_q, opq5_d;
  logic [BPP-1:0]           sel6_q, sel6_d, color7_q;
  logic                     found_c;
  logic                     unused_c;

  assign frame_start_c = (ext_count_h == '0) && (ext_count_v == '0);
  assign bitmap_length = 32'(NS) << ADDR_BITS;
  assign bitmap_dout   = '0;
  assign reg_dout      = rd_q;
  assign ext_color     = color7_q;
  assign unused_c      = ^{bitmap_oe, reg_din};

  // Software writes land in the shadow attribute copies; colour key is live
  always_comb begin
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    sc_sh_d = sc_sh_q;
    en_sh_d = en_sh_q;
    key_d   = key_q;
    if (reg_we) begin
      for (int i = 0; i < NS; i++) begin
        if (reg_address[7:2] == 6'(i)) begin
          case (reg_address[1:0])
            2'd0:    x_sh_d[i]  = reg_din[15:0];
            2'd1:    y_sh_d[i]  = reg_din[15:0];
            2'd2:    sc_sh_d[i] = reg_din[3:0];
            default: en_sh_d[i] = reg_din[0];
          endcase
        end
      end
      if (reg_address == 8'(REG_KEY)) key_d = reg_din[BPP-1:0];
    end
  end

`ifdef MULTI_SPRITE_COLLISION_EN
  logic [NS-1:0] coll_q, coll_d, clr_c;

  // Sticky flags; a new hit overrides a simultaneous write-1-to-clear
  always_comb begin
    clr_c = '0;
    if (reg_we && (reg_address == 8'(REG_COLL))) clr_c = reg_din[NS-1:0];
    coll_d = coll_q & ~clr_c;
    if ((opq5_q & (opq5_q - NS'(1))) != '0) coll_d = coll_d | opq5_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) coll_q <= '0;
    else       coll_q <= coll_d;
  end
`endif

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NS; i++) begin
      if (reg_address[7:2] == 6'(i)) begin
        case (reg_address[1:0])
          2'd0:    rd_d = {{16{x_sh_q[i][15]}}, x_sh_q[i]};
          2'd1:    rd_d = {{16{y_sh_q[i][15]}}, y_sh_q[i]};
          2'd2:    rd_d = 32'(sc_sh_q[i]);
          default: rd_d = 32'(en_sh_q[i]);
        endcase
      end
    end
    if (reg_address == 8'(REG_KEY)) rd_d = 32'(key_q);
`ifdef MULTI_SPRITE_COLLISION_EN
    if (reg_address == 8'(REG_COLL)) rd_d = 32'(coll_q);
`endif
  end

  // Per-sprite position, scaling and bounds (stages 1-2) plus transparency (stage 5)
  always_comb begin
    dx0_d  = '0;
    dy0_d  = '0;
    dx1_c  = '0;
    dy1_c  = '0;
    px2_d  = '0;
    py2_d  = '0;
    in2_d  = '0;
    opq5_d = '0;
    for (int i = 0; i < NS; i++) begin
      dx0_d[i] = {{16{ext_count_h[15]}}, ext_count_h[15:0]} - {{16{x_ac_q[i][15]}}, x_ac_q[i]};
      dy0_d[i] = {{16{ext_count_v[15]}}, ext_count_v[15:0]} - {{16{y_ac_q[i][15]}}, y_ac_q[i]};
      dx1_c[i] = 32'(($signed(dx0_q[i]) <<< sc1_q[i]) >>> 8);
      dy1_c[i] = 32'(($signed(dy0_q[i]) <<< sc1_q[i]) >>> 8);
      px2_d[i] = dx1_c[i][WB-1:0];
      py2_d[i] = dy1_c[i][HB-1:0];
      in2_d[i] = en1_q[i]
               && !dx1_c[i][31] && (dx1_c[i][30:0] < 31'(SPR_W))
               && !dy1_c[i][31] && (dy1_c[i][30:0] < 31'(SPR_H));
      opq5_d[i] = in4_q[i] && (rdata4_c[i] != key_q);
    end
  end

  // Lowest-index opaque sprite wins
  always_comb begin
    sel6_d  = '0;
    found_c = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (opq5_q[i] && !found_c) begin
        sel6_d  = pix5_q[i];
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      sc_sh_q  <= '0;
      en_sh_q  <= '0;
      x_ac_q   <= '0;
      y_ac_q   <= '0;
      sc_ac_q  <= '0;
      en_ac_q  <= '0;
      key_q    <= '0;
      rd_q     <= '0;
      dx0_q    <= '0;
      dy0_q    <= '0;
      sc1_q    <= '0;
      en1_q    <= '0;
      px2_q    <= '0;
      py2_q    <= '0;
      in2_q    <= '0;
      addr3_q  <= '0;
      in3_q    <= '0;
      in4_q    <= '0;
      pix5_q   <= '0;
      opq5_q   <= '0;
      sel6_q   <= '0;
      color7_q <= '0;
    end else begin
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      sc_sh_q <= sc_sh_d;
      en_sh_q <= en_sh_d;
      key_q   <= key_d;
      rd_q    <= rd_d;
      if (frame_start_c) begin
        x_ac_q  <= x_sh_q;
        y_ac_q  <= y_sh_q;
        sc_ac_q <= sc_sh_q;
        en_ac_q <= en_sh_q;
      end
      dx0_q <= dx0_d;
      dy0_q <= dy0_d;
      sc1_q <= sc_ac_q;
      en1_q <= en_ac_q;
      px2_q <= px2_d;
      py2_q <= py2_d;
      in2_q <= in2_d;
      for (int i = 0; i < NS; i++) addr3_q[i] <= {py2_q[i], px2_q[i]};
      in3_q    <= in2_q;
      in4_q    <= in3_q;
      pix5_q   <= rdata4_c;
      opq5_q   <= opq5_d;
      sel6_q   <= sel6_d;
      color7_q <= sel6_q;
    end
  end

  // One read-first bitmap bank per sprite (stage 4); contents are not reset
  for (genvar g = 0; g < NS; g++) begin : g_bank
    logic [BPP-1:0] mem [DEPTH];
    logic [BPP-1:0] rdata_q;
    logic           we_c;

    assign we_c        = bitmap_we && ((bitmap_address >> ADDR_BITS) == 32'(g));
    assign rdata4_c[g] = rdata_q;

    always_ff @(posedge clk) begin
      if (we_c) mem[bitmap_address[ADDR_BITS-1:0]] <= bitmap_din;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= mem[addr3_q[g]];
    end
  end

endmodule

// File: tb/tb_multi_sprite.sv
// Directed bench for multi_sprite: placement, priority, colour key, shadowing, scaling, reset, collisions.
module tb_multi_sprite;

  localparam int ADDR_BITS = 13;
  localparam int BLANK     = 1000;

  logic        clk;
  logic        reset;
  logic [31:0] bitmap_length;
  logic [31:0] bitmap_address;
  logic [7:0]  bitmap_din;
  logic [7:0]  bitmap_dout;
  logic        bitmap_we;
  logic        bitmap_oe;
  logic [7:0]  reg_address;
  logic [31:0] reg_din;
  logic        reg_we;
  logic [31:0] reg_dout;
  logic [31:0] ext_count_h;
  logic [31:0] ext_count_v;
  logic [7:0]  ext_color;

  int n_checks = 0;
  int n_pass   = 0;

  multi_sprite dut (
    .clk            (clk),
    .reset          (reset),
    .bitmap_length  (bitmap_length),
    .bitmap_address (bitmap_address),
    .bitmap_din     (bitmap_din),
    .bitmap_dout    (bitmap_dout),
    .bitmap_we      (bitmap_we),
    .bitmap_oe      (bitmap_oe),
    .reg_address    (reg_address),
    .reg_din        (reg_din),
    .reg_we         (reg_we),
    .reg_dout       (reg_dout),
    .ext_count_h    (ext_count_h),
    .ext_count_v    (ext_count_v),
    .ext_color      (ext_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic blank();
    ext_count_h = 32'(BLANK);
    ext_count_v = 32'(BLANK);
  endtask

  task automatic reg_write(input int a, input int d);
    reg_address = 8'(a);
    reg_din     = 32'(d);
    reg_we      = 1'b1;
    @(posedge clk); #1;
    reg_we      = 1'b0;
  endtask

  task automatic reg_check(input string tag, input int a, input int exp);
    reg_address = 8'(a);
    @(posedge clk); #1;
    check_eq(tag, reg_dout, 32'(exp));
  endtask

  task automatic bm_write(input int bank, input int addr, input int d);
    bitmap_address = (32'(bank) << ADDR_BITS) | 32'(addr);
    bitmap_din     = 8'(d);
    bitmap_we      = 1'b1;
    @(posedge clk); #1;
    bitmap_we      = 1'b0;
  endtask

  task automatic frame_start();
    ext_count_h = 0;
    ext_count_v = 0;
    @(posedge clk); #1;
    blank();
  endtask

  task automatic frame_start_with_write(input int a, input int d);
    ext_count_h = 0;
    ext_count_v = 0;
    reg_address = 8'(a);
    reg_din     = 32'(d);
    reg_we      = 1'b1;
    @(posedge clk); #1;
    reg_we      = 1'b0;
    blank();
  endtask

  // Single-cycle pixel pulse, result sampled exactly 7 edges later
  task automatic probe(input string tag, input int h, input int v, input int exp);
    ext_count_h = 32'(h);
    ext_count_v = 32'(v);
    @(posedge clk); #1;
    blank();
    repeat (6) @(posedge clk);
    #1;
    check_eq(tag, 32'(ext_color), 32'(exp));
  endtask

  initial begin
    logic [7:0] acc;
    reset          = 1'b1;
    bitmap_address = '0;
    bitmap_din     = '0;
    bitmap_we      = 1'b0;
    bitmap_oe      = 1'b0;
    reg_address    = '0;
    reg_din        = '0;
    reg_we         = 1'b0;
    blank();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_eq("reset_color", 32'(ext_color), 32'h0);
    check_eq("bitmap_length", bitmap_length, 32'd32768);
    check_eq("bitmap_dout", 32'(bitmap_dout), 32'h0);
    reg_check("reset_reg_x0", 0, 0);
    reg_check("reset_reg_key", 17, 0);

    acc = '0;
    for (int v = 0; v < 3; v++) begin
      for (int h = 0; h < 100; h++) begin
        ext_count_h = 32'(h);
        ext_count_v = 32'(v);
        @(posedge clk); #1;
        acc |= ext_color;
      end
    end
    blank();
    repeat (8) begin
      @(posedge clk); #1;
      acc |= ext_color;
    end
    check_eq("reset_frame_dark", 32'(acc), 32'h0);

    // Sprite 0 at (10,20), 1:1
    reg_write(0, 10);
    reg_write(1, 20);
    reg_write(2, 8);
    reg_write(3, 1);
    bm_write(0, 0, 8'h55);
    bm_write(0, 63, 8'h66);
    bm_write(4, 0, 8'h77);
    reg_check("shadow_x0", 0, 10);
    reg_check("shadow_scale0", 2, 8);
    reg_check("shadow_en0", 3, 1);
    probe("before_frame_start", 10, 20, 0);
    frame_start();
    probe("sprite0_origin", 10, 20, 8'h55);
    probe("sprite0_left_edge", 9, 20, 0);
    probe("sprite0_right_col", 73, 20, 8'h66);
    probe("sprite0_past_right", 74, 20, 0);
    probe("sprite0_above", 10, 19, 0);

    // Sprite 1 overlapping sprite 0 at (12,20)
    reg_write(4, 12);
    reg_write(5, 20);
    reg_write(6, 8);
    reg_write(7, 1);
    bm_write(0, 2, 8'h11);
    bm_write(1, 0, 8'h22);
    frame_start();
    probe("priority_low_index", 12, 20, 8'h11);
    reg_write(17, 8'h11);
    reg_check("key_readback", 17, 8'h11);
    probe("colour_key_reveals", 12, 20, 8'h22);
    probe("key_other_pixel", 10, 20, 8'h55);
    reg_write(17, 0);

    reg_write(18, 8'hAB);
    reg_check("oob_read_18", 18, 0);
    reg_check("oob_read_40", 40, 0);
`ifdef MULTI_SPRITE_COLLISION_EN
    reg_check("coll_first_overlap", 16, 3);
    reg_write(16, 4'hF);
    reg_check("coll_cleared", 16, 0);
`else
    reg_write(16, 4'hF);
    reg_check("coll_absent", 16, 0);
`endif

    // Mid-frame move: shadow changes, active position held until frame start
    reg_write(7, 0);
    reg_write(0, 30);
    reg_check("shadow_x_mid", 0, 30);
    probe("old_pos_held", 10, 20, 8'h55);
    frame_start();
    probe("new_pos", 30, 20, 8'h55);
    probe("old_pos_gone", 10, 20, 0);
    frame_start_with_write(0, 50);
    probe("fs_write_not_latched", 30, 20, 8'h55);
    frame_start();
    probe("fs_write_next_frame", 50, 20, 8'h55);
    probe("fs_old_gone", 30, 20, 0);

    // Sprite 2 scaling
    reg_write(3, 0);
    reg_write(8, 100);
    reg_write(9, 40);
    reg_write(10, 7);
    reg_write(11, 1);
    bm_write(2, 0, 8'hA0);
    bm_write(2, 1, 8'hA1);
    bm_write(2, 2, 8'hA2);
    bm_write(2, 4, 8'hA4);
    bm_write(2, 63, 8'hBF);
    frame_start();
    probe("zoom_h101", 101, 40, 8'hA0);
    probe("zoom_h102", 102, 40, 8'hA1);
    probe("zoom_h103_v41", 103, 41, 8'hA1);
    probe("zoom_left_out", 99, 40, 0);
    probe("zoom_h226", 226, 40, 8'hBF);
    probe("zoom_h227", 227, 40, 8'hBF);
    probe("zoom_right_out", 228, 40, 0);
    reg_write(10, 9);
    frame_start();
    probe("shrink_h100", 100, 40, 8'hA0);
    probe("shrink_h101", 101, 40, 8'hA2);
    probe("shrink_h102", 102, 40, 8'hA4);
    probe("shrink_right_out", 132, 40, 0);

    // Sprites 1 and 2 stacked at (200,60)
    reg_write(4, 200);
    reg_write(5, 60);
    reg_write(6, 8);
    reg_write(7, 1);
    reg_write(8, 200);
    reg_write(9, 60);
    reg_write(10, 8);
    bm_write(1, 0, 8'h31);
    bm_write(2, 0, 8'h32);
`ifdef MULTI_SPRITE_COLLISION_EN
    reg_write(16, 4'hF);
`endif
    frame_start();
    probe("stack_priority", 200, 60, 8'h31);
`ifdef MULTI_SPRITE_COLLISION_EN
    reg_check("coll_set_1_2", 16, 4'b0110);
    reg_write(16, 4'b0010);
    reg_check("coll_w1c", 16, 4'b0100);
    reg_write(16, 4'hF);
    reg_check("coll_clear_all", 16, 0);
    ext_count_h = 200;
    ext_count_v = 60;
    @(posedge clk); #1;
    blank();
    repeat (4) @(posedge clk);
    #1;
    reg_address = 8'd16;
    reg_din     = 32'b0110;
    reg_we      = 1'b1;
    @(posedge clk); #1;
    reg_we      = 1'b0;
    reg_check("coll_set_beats_clear", 16, 4'b0110);
`else
    reg_check("coll_still_absent", 16, 0);
`endif

    // Asynchronous reset mid-frame
    ext_count_h = 200;
    ext_count_v = 60;
    repeat (8) @(posedge clk);
    #1;
    check_eq("hold_visible", 32'(ext_color), 32'h31);
    #3 reset = 1'b1;
    #1 check_eq("async_reset_dark", 32'(ext_color), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("post_reset_dark", 32'(ext_color), 32'h0);
    frame_start();
    probe("post_reset_frame", 200, 60, 0);
    reg_check("post_reset_attr", 4, 0);
    reg_check("post_reset_key", 17, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
